sha256_msg_sched: RTL and testbench



---
 rtl/sha256_pkg.sv | 36 +++
 rtl/sha256_msg_sched_if.sv | 26 ++
 rtl/sha256_sched_sigma.sv | 22 ++
 rtl/sha256_msg_sched.sv | 83 ++++++++
 tb/tb_sha256_msg_sched.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: round constants, sizes, FSM encoding.
// The K table is only referenced when SHA256_KROM_EN is defined.
package sha256_pkg;

    localparam int unsigned SHA256_ROUNDS = 64;
    localparam int unsigned SHA256_WIN    = 16;

    typedef enum logic {
        StIdle,
        StRun
    } sched_state_e;

    localparam logic [31:0] K [SHA256_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Block-in / schedule-word-out handshake bundle for sha256_msg_sched.
// slave = the schedule generator, master = the surrounding upstream/round stages.
interface sha256_msg_sched_if;
    import sha256_pkg::*;

    logic                        blk_vld_i;
    logic                        blk_rdy_o;
    logic [SHA256_WIN*32-1:0]    blk_data_i;
    logic                        w_vld_o;
    logic                        w_rdy_i;
    logic [31:0]                 w_o;
    logic [31:0]                 k_o;
    logic [5:0]                  rnd_o;
    logic                        w_last_o;

    modport slave (
        input  blk_vld_i, blk_data_i, w_rdy_i,
        output blk_rdy_o, w_vld_o, w_o, k_o, rnd_o, w_last_o
    );

    modport master (
        output blk_vld_i, blk_data_i, w_rdy_i,
        input  blk_rdy_o, w_vld_o, w_o, k_o, rnd_o, w_last_o
    );

endinterface

// File: rtl/sha256_sched_sigma.sv
// Combinational next-word function: W(t+16) = s1(W(t+14)) + W(t+9) + s0(W(t+1)) + W(t),
// all mod 2^32.
module sha256_sched_sigma
    import sha256_pkg::*;
(
    input  logic [31:0] w0_i,
    input  logic [31:0] w1_i,
    input  logic [31:0] w9_i,
    input  logic [31:0] w14_i,
    output logic [31:0] w16_o
);

    logic [31:0] s0;
    logic [31:0] s1;

    always_comb begin
        s0    = rotr(w1_i, 7) ^ rotr(w1_i, 18) ^ (w1_i >> 3);
        s1    = rotr(w14_i, 17) ^ rotr(w14_i, 19) ^ (w14_i >> 10);
        w16_o = s1 + w9_i + s0 + w0_i;
    end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule generator: streams W0..W63 with Kt and t from a 16-word window.
// Define SHA256_KROM_EN to compile in the K table; otherwise k_o is tied to zero.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    sha256_msg_sched_if.slave       bus
);

    sched_state_e state_q, state_d;
    logic [5:0]   rnd_q, rnd_d;
    logic [31:0]  win_q [SHA256_WIN];
    logic [31:0]  win_d [SHA256_WIN];
    logic [31:0]  w_next;

    sha256_sched_sigma u_sigma (
        .w0_i  (win_q[0]),
        .w1_i  (win_q[1]),
        .w9_i  (win_q[9]),
        .w14_i (win_q[14]),
        .w16_o (w_next)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        win_d   = win_q;
        unique case (state_q)
            StIdle: begin
                if (bus.blk_vld_i) begin
                    for (int i = 0; i < SHA256_WIN; i++) begin
                        win_d[i] = bus.blk_data_i[511 - 32*i -: 32];
                    end
                    rnd_d   = 6'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.w_rdy_i) begin
                    for (int i = 0; i < SHA256_WIN - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    // Past t = 47 this word is never emitted; shifting anyway keeps the path uniform.
                    win_d[SHA256_WIN-1] = w_next;
                    rnd_d = rnd_q + 6'd1;
                    if (rnd_q == 6'd63) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rnd_q   <= 6'd0;
            for (int i = 0; i < SHA256_WIN; i++) begin
                win_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        bus.blk_rdy_o = (state_q == StIdle);
        bus.w_vld_o   = (state_q == StRun);
        bus.w_o       = win_q[0];
        bus.rnd_o     = rnd_q;
        bus.w_last_o  = (state_q == StRun) && (rnd_q == 6'd63);
`ifdef SHA256_KROM_EN
        bus.k_o       = K[rnd_q];
`else
        bus.k_o       = 32'h0;
`endif
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: random blocks and stalls against an
// array-based schedule model.
module tb_sha256_msg_sched;

    typedef logic [31:0] sched_t [64];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    sha256_msg_sched_if bus ();

    sha256_msg_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t ref_sched(input logic [511:0] blk);
        sched_t w;
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        return w;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom;
        return b;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, " w_vld"}, bus.w_vld_o, 0);
        check({tag, " blk_rdy"}, bus.blk_rdy_o, 1);
        check({tag, " w"}, bus.w_o, 0);
        check({tag, " rnd"}, bus.rnd_o, 0);
        check({tag, " last"}, bus.w_last_o, 0);
`ifdef SHA256_KROM_EN
        check({tag, " k"}, bus.k_o, 32'h428a2f98);
`else
        check({tag, " k"}, bus.k_o, 0);
`endif
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic accept(input logic [511:0] data, input logic [511:0] next, input bit keep);
        int n = 0;
        bus.blk_vld_i  = 1'b1;
        bus.blk_data_i = data;
        while (!bus.blk_rdy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept blk_rdy", bus.blk_rdy_o, 1);
        @(posedge clk);
        #1;
        if (keep) bus.blk_data_i = next;
        else bus.blk_vld_i = 1'b0;
    endtask

    // Every cycle (stalled or not) the outputs must show the current word.
    task automatic stream(input sched_t exp, input int stall_pct, input int n_words);
        int t = 0;
        int cyc = 0;
        while (t < n_words && cyc < 4000) begin
            @(negedge clk);
            check($sformatf("w_vld t=%0d", t), bus.w_vld_o, 1);
            check($sformatf("w t=%0d", t), bus.w_o, exp[t]);
            check($sformatf("rnd t=%0d", t), bus.rnd_o, t);
            check($sformatf("last t=%0d", t), bus.w_last_o, t == 63);
            check($sformatf("blk_rdy t=%0d", t), bus.blk_rdy_o, 0);
`ifdef SHA256_KROM_EN
            if (t == 0) check("k t=0", bus.k_o, 32'h428a2f98);
            else if (t == 63) check("k t=63", bus.k_o, 32'hc67178f2);
`else
            check($sformatf("k t=%0d", t), bus.k_o, 0);
`endif
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                bus.w_rdy_i = 1'b0;
            end else begin
                bus.w_rdy_i = 1'b1;
                t++;
            end
            cyc++;
        end
        check("stream words", t, n_words);
    endtask

    task automatic post_block(input string tag);
        @(negedge clk);
        check({tag, " idle blk_rdy"}, bus.blk_rdy_o, 1);
        check({tag, " idle w_vld"}, bus.w_vld_o, 0);
        check({tag, " idle last"}, bus.w_last_o, 0);
    endtask

    sched_t       e_abc, e1, e2;
    logic [511:0] abc, b1, b2;

    initial begin
        bus.blk_vld_i  = 1'b0;
        bus.blk_data_i = '0;
        bus.w_rdy_i    = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks("por");
        rst = 1'b0;

        abc   = {32'h61626380, 448'h0, 32'h00000018};
        e_abc = ref_sched(abc);
        e_abc[16] = 32'h61626380;
        e_abc[17] = 32'h000f0000;
        e_abc[18] = 32'h7da86405;
        e_abc[19] = 32'h600003c6;

        accept(abc, '0, 0);
        stream(e_abc, 0, 64);
        post_block("abc");

        accept(abc, '0, 0);
        stream(e_abc, 50, 64);
        post_block("abc stall");

        b1 = '1;
        e1 = ref_sched(b1);
        accept(b1, '0, 0);
        stream(e1, 30, 64);
        post_block("ones");

        b1 = rand_block();
        b2 = rand_block();
        e1 = ref_sched(b1);
        e2 = ref_sched(b2);
        accept(b1, b2, 1);
        stream(e1, 0, 64);
        @(negedge clk);
        check("b2b gap blk_rdy", bus.blk_rdy_o, 1);
        check("b2b gap w_vld", bus.w_vld_o, 0);
        @(posedge clk);
        #1;
        bus.blk_vld_i = 1'b0;
        stream(e2, 0, 64);
        post_block("b2b");

        accept(abc, '0, 0);
        stream(e_abc, 0, 30);
        @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks("mid rst");
        @(negedge clk);
        rst = 1'b0;
        accept(abc, '0, 0);
        stream(e_abc, 0, 64);
        post_block("after rst");

        for (int i = 0; i < 3; i++) begin
            b1 = rand_block();
            e1 = ref_sched(b1);
            accept(b1, '0, 0);
            stream(e1, 25, 64);
            post_block($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
